// File: rtl/regfile_dbg_port.sv
// Debug-side initiator for the register file: halts the core, then performs single
// reads, single writes or register dumps through the write port and one read port.
module regfile_dbg_port #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic            cmd_dump,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [XLEN-1:0] cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [AW-1:0]   rsp_addr,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_last,
  output logic            halt_req,
  input  logic            dbg_halted,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic [AW-1:0]   rf_ra,
  input  logic [XLEN-1:0] rf_rd
);

  typedef enum logic [2:0] {IDLE, HALT, RD, WR, RESP} state_e;

  localparam logic [AW-1:0] LastAddr = AW'(NREGS - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              dump_q, dump_d;
  logic              write_q, write_d;
  logic              cmdReady_q, cmdReady_d;
  logic              haltReq_q, haltReq_d;
  logic              rspValid_q, rspValid_d;
  logic [AW-1:0]     rspAddr_q, rspAddr_d;
  logic [XLEN-1:0]   rspData_q, rspData_d;
  logic              rspLast_q, rspLast_d;
  logic              rfWe_q, rfWe_d;
  logic [AW-1:0]     rfWa_q, rfWa_d;
  logic [XLEN-1:0]   rfWd_q, rfWd_d;
  logic [AW-1:0]     rfRa_q, rfRa_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      dump_q     <= 1'b0;
      write_q    <= 1'b0;
      cmdReady_q <= 1'b1;
      haltReq_q  <= 1'b0;
      rspValid_q <= 1'b0;
      rspAddr_q  <= '0;
      rspData_q  <= '0;
      rspLast_q  <= 1'b0;
      rfWe_q     <= 1'b0;
      rfWa_q     <= '0;
      rfWd_q     <= '0;
      rfRa_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dump_q     <= dump_d;
      write_q    <= write_d;
      cmdReady_q <= cmdReady_d;
      haltReq_q  <= haltReq_d;
      rspValid_q <= rspValid_d;
      rspAddr_q  <= rspAddr_d;
      rspData_q  <= rspData_d;
      rspLast_q  <= rspLast_d;
      rfWe_q     <= rfWe_d;
      rfWa_q     <= rfWa_d;
      rfWd_q     <= rfWd_d;
      rfRa_q     <= rfRa_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dump_d     = dump_q;
    write_d    = write_q;
    cmdReady_d = cmdReady_q;
    haltReq_d  = haltReq_q;
    rspValid_d = rspValid_q;
    rspAddr_d  = rspAddr_q;
    rspData_d  = rspData_q;
    rspLast_d  = rspLast_q;
    rfWe_d     = rfWe_q;
    rfWa_d     = rfWa_q;
    rfWd_d     = rfWd_q;
    rfRa_d     = rfRa_q;

    unique case (state_q)
      IDLE: begin
        // Dump takes priority over write; cmd_write is meaningless for a dump.
        if (cmd_valid && cmdReady_q) begin
          addr_d     = cmd_addr;
          wdata_d    = cmd_wdata;
          dump_d     = cmd_dump;
          write_d    = !cmd_dump && cmd_write;
          cmdReady_d = 1'b0;
          haltReq_d  = 1'b1;
          state_d    = HALT;
        end
      end
      HALT: begin
        if (dbg_halted) begin
          rfRa_d = addr_q;
          if (write_q) begin
            rfWe_d  = (addr_q != '0);
            rfWa_d  = addr_q;
            rfWd_d  = wdata_q;
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        rspValid_d = 1'b1;
        rspAddr_d  = addr_q;
        rspData_d  = (addr_q == '0) ? '0 : rf_rd;
        rspLast_d  = !dump_q || (addr_q == LastAddr);
        state_d    = RESP;
      end
      WR: begin
        rfWe_d     = 1'b0;
        rspValid_d = 1'b1;
        rspAddr_d  = addr_q;
        rspData_d  = (addr_q == '0) ? '0 : wdata_q;
        rspLast_d  = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        // A dump keeps the core halted between beats and never wraps past the last register.
        if (rsp_ready) begin
          rspValid_d = 1'b0;
          if (dump_q && (addr_q != LastAddr)) begin
            addr_d  = addr_q + AW'(1);
            rfRa_d  = addr_q + AW'(1);
            state_d = RD;
          end else begin
            haltReq_d  = 1'b0;
            cmdReady_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = cmdReady_q;
  assign halt_req  = haltReq_q;
  assign rsp_valid = rspValid_q;
  assign rsp_addr  = rspAddr_q;
  assign rsp_data  = rspData_q;
  assign rsp_last  = rspLast_q;
  assign rf_we     = rfWe_q;
  assign rf_wa     = rfWa_q;
  assign rf_wd     = rfWd_q;
  assign rf_ra     = rfRa_q;

endmodule
